// File: rtl/heater_duty_ctrl.sv
// Duty-cycle scheduler for the ring-oscillator heater.
// Turns a latched period/on-time/run-length configuration into a registered
// heater enable word and a status word (busy, sticky done, period count).
module heater_duty_ctrl #(
  parameter int BUS_WIDTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [BUS_WIDTH-1:0] cfg_reg,
  input  logic [BUS_WIDTH-1:0] run_len,
  input  logic                 start,
  input  logic                 stop,
  output logic [BUS_WIDTH-1:0] heat_ctrl,
  output logic [BUS_WIDTH-1:0] status
);

  localparam int CNT_BITS = BUS_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     on_q, on_d;
  logic [CNT_W-1:0]     phase_q, phase_d;
  logic [BUS_WIDTH-1:0] run_len_q, run_len_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic                 done_q, done_d;
  logic                 heat_q, busy_q;

  logic [CNT_W-1:0]     cfg_period;
  logic [CNT_W-1:0]     cfg_on;

  assign cfg_period = cfg_reg[CNT_W-1:0];
  assign cfg_on     = cfg_reg[2*CNT_W-1:CNT_W];

  // Period count saturates instead of wrapping so software never sees it roll over.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    if (&v) return v;
    else    return v + CNT_BITS'(1);
  endfunction

  // Next-state: run acceptance, phase stepping, period accounting and abort.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    on_d      = on_q;
    phase_d   = phase_q;
    run_len_d = run_len_q;
    count_d   = count_q;
    done_d    = done_q;
    case (state_q)
      IDLE, DONE: begin
        // stop wins over a simultaneous start, leaving the state untouched
        if (start && !stop) begin
          period_d  = cfg_period;
          on_d      = cfg_on;
          run_len_d = run_len;
          count_d   = '0;
          done_d    = 1'b0;
          phase_d   = '0;
          if (cfg_period == '0 || cfg_on == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ON;
          end
        end
      end
      ON, OFF: begin
        if (stop) begin
          // partial period is dropped from the count
          state_d = DONE;
          done_d  = 1'b1;
        end else if (phase_q == period_q - CNT_W'(1)) begin
          phase_d = '0;
          count_d = sat_inc(count_q);
          if (run_len_q != '0 && BUS_WIDTH'(count_d) == run_len_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ON;
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
          // on-time >= period keeps this true for the whole period
          state_d = (phase_d < on_q) ? ON : OFF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched configuration, counters and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      period_q  <= '0;
      on_q      <= '0;
      phase_q   <= '0;
      run_len_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      heat_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      on_q      <= on_d;
      phase_q   <= phase_d;
      run_len_q <= run_len_d;
      count_q   <= count_d;
      done_q    <= done_d;
      heat_q    <= (state_d == ON);
      busy_q    <= (state_d == ON) || (state_d == OFF);
    end
  end

  assign heat_ctrl = {{(BUS_WIDTH-1){1'b0}}, heat_q};
  assign status    = {count_q, done_q, busy_q};

endmodule

// File: tb/tb_heater_duty_ctrl.sv
// Directed bench for heater_duty_ctrl: reset, bounded runs, degenerate
// configurations, continuous run with stop, and asynchronous reset mid-run.
module tb_heater_duty_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic [31:0] cfg_reg;
  logic [31:0] run_len;
  logic        start;
  logic        stop;
  logic [31:0] heat_ctrl;
  logic [31:0] status;

  int n_checks = 0;
  int n_pass   = 0;

  heater_duty_ctrl #(.BUS_WIDTH(32), .CNT_W(16)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .cfg_reg   (cfg_reg),
    .run_len   (run_len),
    .start     (start),
    .stop      (stop),
    .heat_ctrl (heat_ctrl),
    .status    (status)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // period=10, on=3, run_len=2; start sampled at edge 0
  task automatic run_p10_on3();
    cfg_reg = {16'd3, 16'd10};
    run_len = 32'd2;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("p10on3_heat_c%0d", c), heat_ctrl,
          ((c >= 1 && c <= 3) || (c >= 11 && c <= 13)) ? 32'd1 : 32'd0);
      if (c == 11) chk("p10on3_status_c11", status, 32'h0000_0005);
      if (c < 21) tick();
    end
    chk("p10on3_status_c21", status, 32'h0000_000A);
    tick();
    chk("p10on3_status_c22", status, 32'h0000_000A);
  endtask

  initial begin
    // reset with arbitrary inputs and a start pulse
    Reset_n = 1'b0;
    cfg_reg = 32'hDEAD_BEEF;
    run_len = 32'h1234_5678;
    start   = 1'b1;
    stop    = 1'b0;
    tick();
    chk("rst_heat", heat_ctrl, 32'd0);
    chk("rst_status", status, 32'd0);
    tick();
    chk("rst_start_heat", heat_ctrl, 32'd0);
    chk("rst_start_status", status, 32'd0);
    start = 1'b0;
    #2 Reset_n = 1'b1;
    tick();
    chk("post_rst_status", status, 32'd0);

    run_p10_on3();

    // on-time of zero: immediate done, heater never on
    cfg_reg = {16'd0, 16'd10};
    run_len = 32'd5;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("on0_status_c1", status, 32'h0000_0002);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("on0_heat_c%0d", c), heat_ctrl, 32'd0);
      tick();
    end
    chk("on0_status_c5", status, 32'h0000_0002);

    // period of zero: same behaviour
    cfg_reg = {16'd3, 16'd0};
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("per0_status_c1", status, 32'h0000_0002);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("per0_heat_c%0d", c), heat_ctrl, 32'd0);
      tick();
    end

    // on-time longer than period: continuously on for one period
    cfg_reg = {16'd12, 16'd10};
    run_len = 32'd1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("on12_heat_c%0d", c), heat_ctrl, (c <= 10) ? 32'd1 : 32'd0);
      if (c < 11) tick();
    end
    chk("on12_status_c11", status, 32'h0000_0006);

    // continuous run, ignored start at cycle 7, stop at cycle 25
    cfg_reg = {16'd5, 16'd10};
    run_len = 32'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      chk($sformatf("cont_heat_c%0d", c), heat_ctrl, (((c - 1) % 10) < 5) ? 32'd1 : 32'd0);
      if (c == 11) chk("cont_status_c11", status, 32'h0000_0005);
      start = (c == 7);
      stop  = (c == 25);
      if (c == 7) cfg_reg = {16'd4, 16'd4};
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
    chk("stop_heat_c26", heat_ctrl, 32'd0);
    chk("stop_status_c26", status, 32'h0000_000A);

    // simultaneous start+stop in DONE leaves everything unchanged
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_heat", heat_ctrl, 32'd0);
    chk("startstop_status", status, 32'h0000_000A);
    tick();
    chk("startstop_status2", status, 32'h0000_000A);

    // asynchronous reset during ON, then a fresh run
    cfg_reg = {16'd3, 16'd10};
    run_len = 32'd2;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    chk("mid_on_heat_c2", heat_ctrl, 32'd1);
    chk("mid_on_status_c2", status, 32'h0000_0001);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_heat", heat_ctrl, 32'd0);
    chk("async_rst_status", status, 32'd0);
    tick();
    #2 Reset_n = 1'b1;
    tick();
    chk("after_rst_status", status, 32'd0);
    run_p10_on3();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
